// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply/divide unit with HI/LO result registers.
// One shift-add or restoring shift-subtract step runs per cycle in RUN.
// Signed operations work on magnitudes and fix the signs when the result is written.
module mul_div_unit (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_s;
   logic        accept_s;

   logic [4:0]  count_r;
   logic        is_div_r;
   logic        res_neg_r;
   logic        rem_neg_r;
   logic        dz_r;
   logic [31:0] opnd_r;
   logic [63:0] acc_r;

   logic [32:0] mul_sum_s;
   logic [32:0] div_shift_s;
   logic [31:0] div_sub_s;
   logic        div_fits_s;
   logic [63:0] step_acc_s;

   logic [63:0] prod_s;
   logic [31:0] fin_hi_s;
   logic [31:0] fin_lo_s;

   logic        busy_r;
   logic        done_r;
   logic        dbz_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;

   // Magnitude of an operand: negate only when the operation is signed and the value is negative.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic signed_op);
      logic [31:0] m;
      if (signed_op && v[31]) begin
         m = ~v + 32'd1;
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Two's-complement negation helpers used by the sign-correction stage.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   // Next-state logic; a start is only taken while IDLE.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_s  = RUN;
               accept_s = 1'b1;
            end else begin
               state_s  = IDLE;
            end
         end
         RUN: begin
            if (count_r == 5'd0) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // One iteration step. Multiply: acc = {partial, multiplier}, add multiplicand when
   // the current multiplier bit is set, then shift right. Divide: acc = {rem, quotient},
   // shift left one bit and keep the subtraction only when the divisor fits.
   always_comb begin
      mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
      div_shift_s = {acc_r[63:32], acc_r[31]};
      div_fits_s  = (div_shift_s >= {1'b0, opnd_r});
      div_sub_s   = 32'(div_shift_s - {1'b0, opnd_r});
      if (is_div_r) begin
         if (div_fits_s) begin
            step_acc_s = {div_sub_s, acc_r[30:0], 1'b1};
         end else begin
            step_acc_s = {div_shift_s[31:0], acc_r[30:0], 1'b0};
         end
      end else begin
         step_acc_s = {mul_sum_s, acc_r[31:1]};
      end
   end

   // Sign correction of the finished magnitudes. A zero divisor leaves the dividend
   // magnitude in the remainder (so hi returns the original a) and forces lo to all ones.
   always_comb begin
      prod_s = res_neg_r ? neg64(acc_r) : acc_r;
      if (is_div_r) begin
         if (dz_r) begin
            fin_lo_s = 32'hFFFF_FFFF;
         end else if (res_neg_r) begin
            fin_lo_s = neg32(acc_r[31:0]);
         end else begin
            fin_lo_s = acc_r[31:0];
         end
         if (rem_neg_r) begin
            fin_hi_s = neg32(acc_r[63:32]);
         end else begin
            fin_hi_s = acc_r[63:32];
         end
      end else begin
         fin_hi_s = prod_s[63:32];
         fin_lo_s = prod_s[31:0];
      end
   end

   // Operand capture on an accepted start, then one datapath step per RUN cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_r   <= 5'd0;
         is_div_r  <= 1'b0;
         res_neg_r <= 1'b0;
         rem_neg_r <= 1'b0;
         dz_r      <= 1'b0;
         opnd_r    <= 32'd0;
         acc_r     <= 64'd0;
      end else if (accept_s) begin
         is_div_r  <= op[1];
         res_neg_r <= op[0] & (a[31] ^ b[31]);
         rem_neg_r <= op[0] & a[31];
         dz_r      <= op[1] & (b == 32'd0);
         count_r   <= 5'd31;
         if (op[1]) begin
            opnd_r <= mag32(b, op[0]);
            acc_r  <= {32'd0, mag32(a, op[0])};
         end else begin
            opnd_r <= mag32(a, op[0]);
            acc_r  <= {32'd0, mag32(b, op[0])};
         end
      end else if (state_r == RUN) begin
         acc_r   <= step_acc_s;
         count_r <= count_r - 5'd1;
      end
   end

   // Registered outputs: busy tracks RUN/DONE, hi/lo and done update as DONE is left,
   // mthi/mtlo act only in IDLE when no start is taken on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
         dbz_r  <= 1'b0;
         hi_r   <= 32'd0;
         lo_r   <= 32'd0;
      end else begin
         busy_r <= (state_s != IDLE);
         done_r <= (state_r == DONE);
         if (state_r == DONE) begin
            hi_r  <= fin_hi_s;
            lo_r  <= fin_lo_s;
            dbz_r <= dz_r;
         end else if (accept_s) begin
            dbz_r <= 1'b0;
         end else if (state_r == IDLE) begin
            if (mthi) begin
               hi_r <= wdata;
            end
            if (mtlo) begin
               lo_r <= wdata;
            end
         end
      end
   end

   assign busy        = busy_r;
   assign done        = done_r;
   assign hi          = hi_r;
   assign lo          = lo_r;
   assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: a cycle-level behavioural model computes the
// results with plain 64-bit arithmetic and a latency counter; a negedge process compares
// every output each cycle, and directed scenarios add hand-computed literal checks.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        mthi = 1'b0;
   logic        mtlo = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int t_start = 0;
   int lat;
   int bcnt;

   mul_div_unit dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // Cycle counter used for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Architectural result {hi, lo} from plain arithmetic.
   function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
      logic signed [63:0] sx;
      logic signed [63:0] sy;
      int qi;
      int ri;
      logic [63:0] r;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      case (o)
         2'd0: r = {32'd0, x} * {32'd0, y};
         2'd1: r = sx * sy;
         2'd2: begin
            if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else            r = {x % y, x / y};
         end
         default: begin
            if (y == 32'd0) r = {x, 32'hFFFF_FFFF};
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else begin
               qi = $signed(x) / $signed(y);
               ri = $signed(x) % $signed(y);
               r  = {32'(ri), 32'(qi)};
            end
         end
      endcase
      return r;
   endfunction

   // Behavioural model: 33 busy cycles after an accepted start, then a done cycle with the result.
   logic        m_busy = 1'b0;
   logic        m_done = 1'b0;
   logic        m_dbz = 1'b0;
   logic        p_dz = 1'b0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;
   logic [63:0] p_res = 64'd0;
   int          m_cnt = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0; p_dz <= 1'b0;
         m_hi <= 32'd0; m_lo <= 32'd0; p_res <= 64'd0; m_cnt <= 0;
      end else begin
         m_done <= 1'b0;
         if (m_cnt == 0) begin
            if (start) begin
               p_res  <= ref_result(op, a, b);
               p_dz   <= op[1] && (b == 32'd0);
               m_cnt  <= 33;
               m_busy <= 1'b1;
               m_dbz  <= 1'b0;
            end else begin
               if (mthi) m_hi <= wdata;
               if (mtlo) m_lo <= wdata;
            end
         end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               m_busy <= 1'b0;
               m_done <= 1'b1;
               m_hi   <= p_res[63:32];
               m_lo   <= p_res[31:0];
               m_dbz  <= p_dz;
            end
         end
      end
   end

   // Compare every output against the model each cycle.
   always @(negedge clk) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
      chk("div_by_zero", 64'(div_by_zero), 64'(m_dbz));
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t_start = cyc;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
   endtask

   task automatic wait_done(output int l, output int bc);
      l = -1;
      bc = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) begin
            l = cyc - t_start;
            break;
         end
      end
      if (l < 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: no done within 40 cycles of start at cycle %0d", t_start);
      end
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFF_FFFF;
         2: v = 32'h8000_0000;
         3: v = 32'($urandom_range(0, 20));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset_hi", 64'(hi), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);

      // MULTU max x max, with latency and busy length
      issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      chk("multu_latency", 64'(lat), 64'd33);
      chk("multu_busy_cycles", 64'(bcnt), 64'd33);
      chk("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      issue(2'd1, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat, bcnt);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

      issue(2'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, bcnt);
      chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      issue(2'd2, 32'd100, 32'd7);
      wait_done(lat, bcnt);
      chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

      issue(2'd2, 32'h0000_1234, 32'd0);
      wait_done(lat, bcnt);
      chk("divz_latency", 64'(lat), 64'd33);
      chk("divz_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
      chk("divz_flag", 64'(div_by_zero), 64'd1);

      issue(2'd0, 32'd9, 32'd9);
      @(negedge clk);
      chk("dbz_cleared_by_start", 64'(div_by_zero), 64'd0);
      wait_done(lat, bcnt);
      chk("multu_small", {hi, lo}, 64'd81);

      issue(2'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      chk("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});
      chk("div_overflow_flag", 64'(div_by_zero), 64'd0);

      // start and mthi during RUN are ignored
      issue(2'd0, 32'd3, 32'd5);
      repeat (5) @(posedge clk);
      #1 start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF; op = 2'd0; a = 32'd77; b = 32'd77;
      @(posedge clk);
      #1 start = 1'b0; mthi = 1'b0;
      @(negedge clk);
      chk("run_hilo_hold", {hi, lo}, {32'd0, 32'h8000_0000});
      wait_done(lat, bcnt);
      chk("run_ignore_lat", 64'(lat), 64'd33);
      chk("run_ignore_hilo", {hi, lo}, 64'd15);

      // mthi + mtlo together in IDLE
      @(posedge clk);
      #1 mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_A5A5;
      @(posedge clk);
      #1 mthi = 1'b0; mtlo = 1'b0;
      @(negedge clk);
      chk("mthi_mtlo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);

      // start wins over mthi on the same edge
      @(posedge clk);
      #1 start = 1'b1; mthi = 1'b1; wdata = 32'h1111_1111; op = 2'd0; a = 32'd2; b = 32'd3;
      @(posedge clk);
      #1 start = 1'b0; mthi = 1'b0; t_start = cyc;
      @(negedge clk);
      chk("start_beats_mthi", 64'(hi), 64'hA5A5_A5A5);
      wait_done(lat, bcnt);
      chk("start_beats_mthi_res", {hi, lo}, 64'd6);

      // reset in the middle of RUN, then a start one cycle after release
      issue(2'd0, 32'd123, 32'd456);
      repeat (10) @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_hilo", {hi, lo}, 64'd0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1; op = 2'd1; a = 32'hFFFF_FFFB; b = 32'd6; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; t_start = cyc;
      wait_done(lat, bcnt);
      chk("post_reset_lat", 64'(lat), 64'd33);
      chk("post_reset_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);

      // randomized traffic, the compare process checks every cycle
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk);
         #1;
         start = ($urandom_range(0, 3) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = pick();
         b     = pick();
         mthi  = ($urandom_range(0, 7) == 0);
         mtlo  = ($urandom_range(0, 7) == 0);
         wdata = $urandom;
      end
      @(posedge clk);
      #1 start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
